// File: rtl/altera_tse_rx_ordset_detect.sv
// rtl/altera_tse_rx_ordset_detect.sv - 1000BASE-X rx /C/ and /I/ ordered-set detector with match counters
// Optional code-error counter: define TSE_RX_ORDSET_ERRCNT_EN.
`timescale 1ns/1ps
module altera_tse_rx_ordset_detect #(
  parameter int MATCH_COUNT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_ctrl,
  input  logic        rx_errdetect,
  input  logic        rx_disperr,
  input  logic        rx_sync,
  output logic [15:0] rx_config_reg,
  output logic        rx_config_valid,
  output logic        rx_idle,
  output logic        rx_invalid,
  output logic        ability_match,
  output logic        ack_match,
  output logic        idle_match,
  output logic [15:0] err_count
);

  localparam logic [2:0] MC = 3'(MATCH_COUNT);

  typedef enum logic [1:0] {HUNT, K_SEEN, CFG_LO, CFG_HI} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cfg_lo, cfg_lo_nxt;
  logic [15:0] prev_word, prev_word_nxt;
  logic        prev_valid, prev_valid_nxt;
  logic [2:0]  ability_cnt, ability_cnt_nxt;
  logic [2:0]  ack_cnt, ack_cnt_nxt;
  logic [2:0]  idle_cnt, idle_cnt_nxt;
  logic        ev_cfg, ev_idle, ev_inv;
  logic        is_k28_5, code_err;
  logic [15:0] word;

  assign is_k28_5 = rx_ctrl && (rx_data == 8'hBC);
  assign code_err = rx_errdetect || rx_disperr;
  assign word     = {rx_data, cfg_lo};

  // Ordered-set decode: one byte per clock, errors abort any set in progress.
  always_comb begin
    state_nxt  = state;
    cfg_lo_nxt = cfg_lo;
    ev_cfg     = 1'b0;
    ev_idle    = 1'b0;
    ev_inv     = 1'b0;
    if (!rx_sync) begin
      state_nxt = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (is_k28_5) state_nxt = K_SEEN;
        end
        K_SEEN: begin
          if (code_err) begin
            state_nxt = HUNT;
            ev_inv    = 1'b1;
          end else if (!rx_ctrl && (rx_data == 8'hB5 || rx_data == 8'h42)) begin
            state_nxt = CFG_LO;
          end else if (!rx_ctrl && (rx_data == 8'hC5 || rx_data == 8'h50)) begin
            state_nxt = HUNT;
            ev_idle   = 1'b1;
          end else if (is_k28_5) begin
            state_nxt = K_SEEN;
            ev_inv    = 1'b1;
          end else begin
            state_nxt = HUNT;
            ev_inv    = 1'b1;
          end
        end
        CFG_LO: begin
          if (code_err || rx_ctrl) begin
            state_nxt = HUNT;
            ev_inv    = 1'b1;
          end else begin
            cfg_lo_nxt = rx_data;
            state_nxt  = CFG_HI;
          end
        end
        CFG_HI: begin
          state_nxt = HUNT;
          if (code_err || rx_ctrl) ev_inv = 1'b1;
          else                     ev_cfg = 1'b1;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Match counters; a cleared counter also forgets the previous /C/ word.
  always_comb begin
    ability_cnt_nxt = ability_cnt;
    ack_cnt_nxt     = ack_cnt;
    idle_cnt_nxt    = idle_cnt;
    prev_word_nxt   = prev_word;
    prev_valid_nxt  = prev_valid;
    if (!rx_sync || ev_inv) begin
      ability_cnt_nxt = 3'd0;
      ack_cnt_nxt     = 3'd0;
      idle_cnt_nxt    = 3'd0;
      prev_valid_nxt  = 1'b0;
    end else if (ev_idle) begin
      ability_cnt_nxt = 3'd0;
      ack_cnt_nxt     = 3'd0;
      prev_valid_nxt  = 1'b0;
      idle_cnt_nxt    = (idle_cnt >= MC) ? idle_cnt : idle_cnt + 3'd1;
    end else if (ev_cfg) begin
      idle_cnt_nxt = 3'd0;
      if (prev_valid && ({word[15], word[13:0]} == {prev_word[15], prev_word[13:0]}))
        ability_cnt_nxt = (ability_cnt >= MC) ? ability_cnt : ability_cnt + 3'd1;
      else
        ability_cnt_nxt = 3'd1;
      if (word[14] && prev_valid && (word == prev_word))
        ack_cnt_nxt = (ack_cnt >= MC) ? ack_cnt : ack_cnt + 3'd1;
      else
        ack_cnt_nxt = {2'b00, word[14]};
      prev_word_nxt  = word;
      prev_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= HUNT;
      cfg_lo          <= 8'h00;
      prev_word       <= 16'h0000;
      prev_valid      <= 1'b0;
      ability_cnt     <= 3'd0;
      ack_cnt         <= 3'd0;
      idle_cnt        <= 3'd0;
      rx_config_reg   <= 16'h0000;
      rx_config_valid <= 1'b0;
      rx_idle         <= 1'b0;
      rx_invalid      <= 1'b0;
      ability_match   <= 1'b0;
      ack_match       <= 1'b0;
      idle_match      <= 1'b0;
    end else begin
      state           <= state_nxt;
      cfg_lo          <= cfg_lo_nxt;
      prev_word       <= prev_word_nxt;
      prev_valid      <= prev_valid_nxt;
      ability_cnt     <= ability_cnt_nxt;
      ack_cnt         <= ack_cnt_nxt;
      idle_cnt        <= idle_cnt_nxt;
      if (ev_cfg) rx_config_reg <= word;
      rx_config_valid <= ev_cfg;
      rx_idle         <= ev_idle;
      rx_invalid      <= ev_inv;
      ability_match   <= (ability_cnt_nxt >= MC);
      ack_match       <= (ack_cnt_nxt >= MC);
      idle_match      <= (idle_cnt_nxt >= MC);
    end
  end

`ifdef TSE_RX_ORDSET_ERRCNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      err_cnt_q <= 16'h0000;
    else if (rx_sync && code_err && (err_cnt_q != 16'hFFFF))
      err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_altera_tse_rx_ordset_detect.sv
// tb/tb_altera_tse_rx_ordset_detect.sv - directed bench for the rx ordered-set detector
`timescale 1ns/1ps
module tb_altera_tse_rx_ordset_detect;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_ctrl;
  logic        rx_errdetect;
  logic        rx_disperr;
  logic        rx_sync;
  logic [15:0] rx_config_reg;
  logic        rx_config_valid;
  logic        rx_idle;
  logic        rx_invalid;
  logic        ability_match;
  logic        ack_match;
  logic        idle_match;
  logic [15:0] err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  altera_tse_rx_ordset_detect #(.MATCH_COUNT(3)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_ctrl(rx_ctrl),
    .rx_errdetect(rx_errdetect), .rx_disperr(rx_disperr), .rx_sync(rx_sync),
    .rx_config_reg(rx_config_reg), .rx_config_valid(rx_config_valid),
    .rx_idle(rx_idle), .rx_invalid(rx_invalid), .ability_match(ability_match),
    .ack_match(ack_match), .idle_match(idle_match), .err_count(err_count)
  );

  task automatic send(input logic [7:0] d, input logic c, input logic e = 1'b0, input logic p = 1'b0);
    rx_data = d; rx_ctrl = c; rx_errdetect = e; rx_disperr = p;
    @(posedge clk); #1;
  endtask

  task automatic send_cfg(input logic [15:0] w);
    send(8'hBC, 1'b1); send(8'hB5, 1'b0); send(w[7:0], 1'b0); send(w[15:8], 1'b0);
  endtask

  task automatic clear_all;
    rx_sync = 1'b0; send(8'h00, 1'b0); rx_sync = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_sync = 1'b1;
    rx_data = 8'h00; rx_ctrl = 1'b0; rx_errdetect = 1'b0; rx_disperr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (rx_config_reg !== 16'h0000) begin bad++; $display("FAIL reset_cfg got=%h exp=0000", rx_config_reg); end
    total++; if ({rx_config_valid, rx_idle, rx_invalid} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {rx_config_valid, rx_idle, rx_invalid}); end
    total++; if ({ability_match, ack_match, idle_match} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {ability_match, ack_match, idle_match}); end
    total++; if (err_count !== 16'h0000) begin bad++; $display("FAIL reset_errcnt got=%h exp=0000", err_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_flag;
    exp_flag = 3'b100;
    clear_all();
    for (int i = 0; i < 3; i++) begin
      send_cfg(16'h4001);
      total++; if (rx_config_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, rx_config_valid); end
      total++; if (rx_config_reg !== 16'h4001) begin bad++; $display("FAIL b2b_cfg[%0d] got=%h exp=4001", i, rx_config_reg); end
      total++; if ({ability_match, ack_match} !== {2{exp_flag[i]}}) begin bad++; $display("FAIL b2b_match[%0d] got=%b exp=%b", i, {ability_match, ack_match}, {2{exp_flag[i]}}); end
    end
    send(8'h00, 1'b0);
    total++; if (rx_config_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse_len got=%b exp=0", rx_config_valid); end
  endtask

  task automatic test_ability;
    clear_all();
    send_cfg(16'h0001);
    send_cfg(16'h0001);
    total++; if ({ability_match, ack_match} !== 2'b00) begin bad++; $display("FAIL abil_two got=%b exp=00", {ability_match, ack_match}); end
    send_cfg(16'h4001);
    total++; if ({ability_match, ack_match} !== 2'b10) begin bad++; $display("FAIL abil_three got=%b exp=10", {ability_match, ack_match}); end
    total++; if (rx_config_reg !== 16'h4001) begin bad++; $display("FAIL abil_cfg got=%h exp=4001", rx_config_reg); end
  endtask

  task automatic test_idle;
    logic [2:0] exp_idle;
    exp_idle = 3'b100;
    clear_all();
    for (int i = 0; i < 3; i++) begin
      send(8'hBC, 1'b1);
      send((i == 1) ? 8'hC5 : 8'h50, 1'b0);
      total++; if (rx_idle !== 1'b1) begin bad++; $display("FAIL idle_pulse[%0d] got=%b exp=1", i, rx_idle); end
      total++; if (idle_match !== exp_idle[i]) begin bad++; $display("FAIL idle_match[%0d] got=%b exp=%b", i, idle_match, exp_idle[i]); end
    end
    send_cfg(16'h1234);
    total++; if ({rx_config_valid, idle_match} !== 2'b10) begin bad++; $display("FAIL idle_clr got=%b exp=10", {rx_config_valid, idle_match}); end
    send_cfg(16'h1234);
    total++; if (ability_match !== 1'b0) begin bad++; $display("FAIL idle_abil2 got=%b exp=0", ability_match); end
    send_cfg(16'h1234);
    total++; if ({ability_match, ack_match} !== 2'b10) begin bad++; $display("FAIL idle_abil3 got=%b exp=10", {ability_match, ack_match}); end
  endtask

  task automatic test_code_error;
    clear_all();
    repeat (3) send_cfg(16'h4001);
    send(8'hBC, 1'b1);
    send(8'h42, 1'b0, 1'b0, 1'b1);
    total++; if ({rx_invalid, rx_config_valid} !== 2'b10) begin bad++; $display("FAIL err_pulses got=%b exp=10", {rx_invalid, rx_config_valid}); end
    total++; if ({ability_match, ack_match, idle_match} !== 3'b000) begin bad++; $display("FAIL err_flags got=%b exp=000", {ability_match, ack_match, idle_match}); end
    total++; if (rx_config_reg !== 16'h4001) begin bad++; $display("FAIL err_cfg got=%h exp=4001", rx_config_reg); end
  endtask

  task automatic test_aborts;
    clear_all();
    send(8'hBC, 1'b1); send(8'hBC, 1'b1);
    total++; if (rx_invalid !== 1'b1) begin bad++; $display("FAIL abort_kk got=%b exp=1", rx_invalid); end
    send(8'hB5, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
    total++; if ({rx_config_valid, rx_config_reg} !== {1'b1, 16'h3412}) begin bad++; $display("FAIL abort_kk_resume got=%b/%h exp=1/3412", rx_config_valid, rx_config_reg); end
    send(8'hBC, 1'b1); send(8'hB5, 1'b0); send(8'h56, 1'b0); send(8'hBC, 1'b1);
    total++; if ({rx_invalid, rx_config_valid, rx_config_reg} !== {2'b10, 16'h3412}) begin bad++; $display("FAIL abort_hi got=%b/%h exp=10/3412", {rx_invalid, rx_config_valid}, rx_config_reg); end
    send(8'hBC, 1'b1); send(8'h42, 1'b0); send(8'hBC, 1'b1);
    total++; if (rx_invalid !== 1'b1) begin bad++; $display("FAIL abort_lo got=%b exp=1", rx_invalid); end
    send(8'hBC, 1'b1); send(8'h00, 1'b0);
    total++; if (rx_invalid !== 1'b1) begin bad++; $display("FAIL abort_other got=%b exp=1", rx_invalid); end
    send(8'hB5, 1'b0);
    total++; if ({rx_invalid, rx_idle, rx_config_valid} !== 3'b000) begin bad++; $display("FAIL hunt_quiet got=%b exp=000", {rx_invalid, rx_idle, rx_config_valid}); end
  endtask

  task automatic test_sync_drop;
    clear_all();
    repeat (3) send_cfg(16'h4001);
    send(8'hBC, 1'b1); send(8'hB5, 1'b0); send(8'h77, 1'b0);
    rx_sync = 1'b0;
    send(8'h88, 1'b0);
    rx_sync = 1'b1;
    total++; if ({rx_config_valid, rx_invalid, ability_match, ack_match} !== 4'b0000) begin bad++; $display("FAIL sync_drop got=%b exp=0000", {rx_config_valid, rx_invalid, ability_match, ack_match}); end
    total++; if (rx_config_reg !== 16'h4001) begin bad++; $display("FAIL sync_cfg_hold got=%h exp=4001", rx_config_reg); end
    send_cfg(16'h4001);
    total++; if ({rx_config_valid, ability_match} !== 2'b10) begin bad++; $display("FAIL sync_restart got=%b exp=10", {rx_config_valid, ability_match}); end
  endtask

  task automatic test_reset_mid_and_errcnt;
    logic [15:0] exp_err;
`ifdef TSE_RX_ORDSET_ERRCNT_EN
    exp_err = 16'd5;
`else
    exp_err = 16'd0;
`endif
    clear_all();
    repeat (3) send_cfg(16'h4001);
    send(8'hBC, 1'b1); send(8'hB5, 1'b0); send(8'h33, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    total++; if ({rx_config_reg, ability_match, ack_match, rx_config_valid} !== 19'h0) begin bad++; $display("FAIL rst_mid got=%h/%b exp=0000/000", rx_config_reg, {ability_match, ack_match, rx_config_valid}); end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    send(8'h44, 1'b0);
    total++; if ({rx_config_valid, rx_config_reg} !== 17'h0) begin bad++; $display("FAIL rst_fresh got=%b/%h exp=0/0000", rx_config_valid, rx_config_reg); end
    repeat (5) send(8'h00, 1'b0, 1'b1, 1'b0);
    total++; if (err_count !== exp_err) begin bad++; $display("FAIL errcnt got=%0d exp=%0d", err_count, exp_err); end
    rx_sync = 1'b0;
    repeat (2) send(8'h00, 1'b0, 1'b1, 1'b1);
    rx_sync = 1'b1;
    send(8'h00, 1'b0);
    total++; if (err_count !== exp_err) begin bad++; $display("FAIL errcnt_nosync got=%0d exp=%0d", err_count, exp_err); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ability();
    test_idle();
    test_code_error();
    test_aborts();
    test_sync_drop();
    test_reset_mid_and_errcnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
